// File: rtl/azimuth_pkg.sv
// -----------------------------------------------------------------------------
// azimuth_pkg
// Shared definitions for the azimuth capture path and its signal generator:
//   - SIZE_DEFAULT : bits captured per azimuth period (3200)
//   - state_t      : capture FSM state encoding (IDLE=0, CAPTURE=1)
//   - clogb2()     : index width needed to count 0..value-1
// -----------------------------------------------------------------------------
package azimuth_pkg;

    localparam int SIZE_DEFAULT = 3200;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Number of bits needed to hold 0..value-1. Never returns 0, so a
    // degenerate SIZE=1 still gets a 1-bit counter.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/azimuth_signal_capture_if.sv
// -----------------------------------------------------------------------------
// azimuth_signal_capture_if
// Result/consumer bundle of the capture block.
//   DATA        : last completed capture (bit i = sample at i-th CLK_PE)
//   DATA_VALID  : DATA holds a capture not yet acknowledged
//   DATA_ACK    : consumer acknowledge
//   BUSY        : capture in progress
//   OVERRUN     : sticky, a completed capture was dropped
//
// Handshake: a capture is transferred in any cycle where DATA_VALID=1 and
// DATA_ACK=1 at the rising edge. DATA is stable while DATA_VALID=1 and no
// transfer occurs. DATA_ACK with DATA_VALID=0 has no effect. A new capture
// may be loaded in the same cycle as a transfer, keeping DATA_VALID high.
//
// Modports: master = capture block, slave = consumer.
// -----------------------------------------------------------------------------
interface azimuth_signal_capture_if #(
    parameter int SIZE = azimuth_pkg::SIZE_DEFAULT
);
    logic [SIZE-1:0] DATA;
    logic            DATA_VALID;
    logic            DATA_ACK;
    logic            BUSY;
    logic            OVERRUN;

    modport master (
        output DATA,
        output DATA_VALID,
        input  DATA_ACK,
        output BUSY,
        output OVERRUN
    );

    modport slave (
        input  DATA,
        input  DATA_VALID,
        output DATA_ACK,
        input  BUSY,
        input  OVERRUN
    );
endinterface

// File: rtl/azimuth_index_counter.sv
// -----------------------------------------------------------------------------
// azimuth_index_counter
// Bit-index counter for one azimuth period.
//   SYS_CLK : clock
//   RST     : synchronous active-high reset (idx -> 0)
//   CLR     : clear idx to 0 (priority over INC)
//   INC     : advance idx; wraps to 0 at the terminal count, so idx
//             never takes the value SIZE
//   IDX     : current index
//   TC      : IDX == SIZE-1
// -----------------------------------------------------------------------------
module azimuth_index_counter
    import azimuth_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT,
    localparam int BITS = clogb2(SIZE)
) (
    input  logic            SYS_CLK,
    input  logic            RST,
    input  logic            CLR,
    input  logic            INC,
    output logic [BITS-1:0] IDX,
    output logic            TC
);

    assign TC = (IDX == BITS'(SIZE - 1));

    always_ff @(posedge SYS_CLK) begin
        if (RST || CLR) begin
            IDX <= '0;
        end else if (INC) begin
            IDX <= TC ? '0 : IDX + 1'b1;
        end
    end

endmodule

// File: rtl/azimuth_signal_capture.sv
// -----------------------------------------------------------------------------
// azimuth_signal_capture
// Captures SIZE serial samples of SIG_IN, one per CLK_PE tick after TRIG,
// and presents the completed word on the result interface.
//   SYS_CLK   : 100 MHz clock, all logic rising-edge
//   RST       : synchronous active-high reset
//   EN        : capture enable; low aborts any capture, TRIG ignored
//   TRIG      : start/restart pulse; wins over CLK_PE in the same cycle
//   CLK_PE    : sample tick
//   SIG_IN    : serial input, already synchronous
//   cap       : result bundle (DATA/DATA_VALID/DATA_ACK/BUSY/OVERRUN)
//   STATE_DBG : current FSM state
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module azimuth_signal_capture
    import azimuth_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT,
    localparam int BITS = clogb2(SIZE)
) (
    input  logic                     SYS_CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     TRIG,
    input  logic                     CLK_PE,
    input  logic                     SIG_IN,
    azimuth_signal_capture_if.master cap,
    output state_t                   STATE_DBG
);

    state_t          state;
    logic [SIZE-1:0] shadow;
    logic [SIZE-1:0] shadow_wr;
    logic [BITS-1:0] idx;
    logic            idx_tc;
    logic            start;
    logic            take_sample;
    logic            can_load;

    assign STATE_DBG = state;

    always_comb begin
        start       = EN && TRIG;
        take_sample = EN && (state == CAPTURE) && !TRIG && CLK_PE;
        // The slot is free if empty or being drained in this same cycle.
        can_load    = !cap.DATA_VALID || cap.DATA_ACK;
        // Shadow with the current sample merged in, so the final bit is
        // part of the word that loads into DATA on completion.
        shadow_wr      = shadow;
        shadow_wr[idx] = SIG_IN;
    end

    azimuth_index_counter #(
        .SIZE (SIZE)
    ) u_index_counter (
        .SYS_CLK (SYS_CLK),
        .RST     (RST),
        .CLR     (start || !EN),
        .INC     (take_sample),
        .IDX     (idx),
        .TC      (idx_tc)
    );

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state          <= IDLE;
            shadow         <= '0;
            cap.DATA       <= '0;
            cap.DATA_VALID <= 1'b0;
            cap.BUSY       <= 1'b0;
            cap.OVERRUN    <= 1'b0;
        end else begin
            // Drain; a load below overrides this and keeps VALID high.
            if (cap.DATA_VALID && cap.DATA_ACK) begin
                cap.DATA_VALID <= 1'b0;
            end

            if (!EN) begin
                state    <= IDLE;
                cap.BUSY <= 1'b0;
            end else if (TRIG) begin
                // Start from IDLE or restart mid-capture; no load either way.
                state    <= CAPTURE;
                cap.BUSY <= 1'b1;
                shadow   <= '0;
            end else if (take_sample) begin
                shadow <= shadow_wr;
                if (idx_tc) begin
                    state    <= IDLE;
                    cap.BUSY <= 1'b0;
                    if (can_load) begin
                        cap.DATA       <= shadow_wr;
                        cap.DATA_VALID <= 1'b1;
                    end else begin
                        cap.OVERRUN    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_azimuth_signal_capture.sv
// -----------------------------------------------------------------------------
// tb_azimuth_signal_capture
// Directed bench for azimuth_signal_capture with SIZE=8. Full captures are
// table driven; restart, collision, aborts and loopback are hand sequences.
// -----------------------------------------------------------------------------
module tb_azimuth_signal_capture;
    import azimuth_pkg::*;

    localparam int SIZE = 8;

    // ---------------- clock / reset ----------------
    logic SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    logic   RST;
    logic   EN;
    logic   TRIG;
    logic   CLK_PE;
    logic   SIG_IN;
    logic   sig_drv;
    logic   loop_mode;
    state_t STATE_DBG;

    azimuth_signal_capture_if #(.SIZE(SIZE)) bus ();

    azimuth_signal_capture #(
        .SIZE (SIZE)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RST       (RST),
        .EN        (EN),
        .TRIG      (TRIG),
        .CLK_PE    (CLK_PE),
        .SIG_IN    (SIG_IN),
        .cap       (bus),
        .STATE_DBG (STATE_DBG)
    );

    // ---------------- signal generator model ----------------
    // Presents gen_pat[k] during the k-th CLK_PE after TRIG.
    logic [SIZE-1:0] gen_pat;
    logic [2:0]      gen_idx;

    always @(posedge SYS_CLK) begin
        if (TRIG) begin
            gen_idx <= 3'd0;
        end else if (CLK_PE && gen_idx != 3'd7) begin
            gen_idx <= gen_idx + 3'd1;
        end
    end

    assign SIG_IN = loop_mode ? gen_pat[gen_idx] : sig_drv;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic pulse_trig();
        TRIG = 1'b1;
        tick();
        TRIG = 1'b0;
    endtask

    task automatic sample(input logic b, input logic ack, input int gap);
        sig_drv     = b;
        CLK_PE      = 1'b1;
        bus.DATA_ACK = ack;
        tick();
        CLK_PE      = 1'b0;
        bus.DATA_ACK = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_ack();
        bus.DATA_ACK = 1'b1;
        tick();
        bus.DATA_ACK = 1'b0;
    endtask

    // Full capture: TRIG then 8 ticks every 4 cycles; optional ack in the
    // completion cycle. Returns right after the completing edge.
    task automatic do_capture(input logic [7:0] pat, input logic ack_done);
        pulse_trig();
        for (int i = 0; i < SIZE; i++) begin
            sample(pat[i], (i == SIZE - 1) ? ack_done : 1'b0, (i == SIZE - 1) ? 0 : 3);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       pre_rst;
        logic [7:0] pat;
        logic       ack_done;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        RST = 1'b1; EN = 1'b1; TRIG = 1'b0; CLK_PE = 1'b0;
        sig_drv = 1'b0; loop_mode = 1'b0; bus.DATA_ACK = 1'b0;
        gen_pat = '0;

        // SIG_IN 1,0,1,1,0,0,1,0 -> 8'b01001101
        vecs[0] = '{1'b1, 8'b01001101, 1'b0, 8'h4D, 1'b1, 1'b0};
        // Second capture while unacknowledged: dropped, overrun
        vecs[1] = '{1'b0, 8'hA5,       1'b0, 8'h4D, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h4D,       1'b0, 8'h4D, 1'b1, 1'b0};
        // Ack in the completion cycle: new word loads, VALID stays high
        vecs[3] = '{1'b0, 8'h3C,       1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h81,       1'b1, 8'h81, 1'b1, 1'b0};

        tick();
        tick();
        RST = 1'b0;

        // Reset state
        chk("rst_data",    {24'd0, bus.DATA}, 32'h00);
        chk("rst_valid",   {31'd0, bus.DATA_VALID}, 32'd0);
        chk("rst_busy",    {31'd0, bus.BUSY}, 32'd0);
        chk("rst_overrun", {31'd0, bus.OVERRUN}, 32'd0);
        chk("rst_state",   {31'd0, STATE_DBG}, 32'd0);

        // Busy during a capture
        pulse_trig();
        chk("busy_after_trig", {31'd0, bus.BUSY}, 32'd1);
        chk("state_capture",   {31'd0, STATE_DBG}, 32'd1);
        do_reset();

        // ---------------- table-driven captures ----------------
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pre_rst) do_reset();
            do_capture(vecs[v].pat, vecs[v].ack_done);
            chk($sformatf("vec%0d_data", v),    {24'd0, bus.DATA}, {24'd0, vecs[v].exp_data});
            chk($sformatf("vec%0d_valid", v),   {31'd0, bus.DATA_VALID}, {31'd0, vecs[v].exp_valid});
            chk($sformatf("vec%0d_overrun", v), {31'd0, bus.OVERRUN}, {31'd0, vecs[v].exp_ovr});
            chk($sformatf("vec%0d_busy", v),    {31'd0, bus.BUSY}, 32'd0);
            repeat (3) tick();
        end

        // ---------------- ack after overrun ----------------
        do_reset();
        do_capture(8'h4D, 1'b0);
        do_capture(8'hA5, 1'b0);
        pulse_ack();
        chk("ack_valid_clr", {31'd0, bus.DATA_VALID}, 32'd0);
        chk("ack_ovr_kept",  {31'd0, bus.OVERRUN}, 32'd1);
        chk("ack_data_kept", {24'd0, bus.DATA}, 32'h4D);
        pulse_ack();
        chk("ack_idle_ignored", {31'd0, bus.DATA_VALID}, 32'd0);

        // ---------------- restart after 5 samples ----------------
        do_reset();
        pulse_trig();
        for (int i = 0; i < 5; i++) sample(1'b0, 1'b0, 3);
        do_capture(8'hFF, 1'b0);
        chk("restart_data",  {24'd0, bus.DATA}, 32'hFF);
        chk("restart_valid", {31'd0, bus.DATA_VALID}, 32'd1);
        chk("restart_ovr",   {31'd0, bus.OVERRUN}, 32'd0);

        // ---------------- TRIG/CLK_PE collision ----------------
        do_reset();
        pulse_trig();
        sample(1'b1, 1'b0, 3);
        sample(1'b1, 1'b0, 3);
        sig_drv = 1'b1;
        TRIG    = 1'b1;
        CLK_PE  = 1'b1;
        tick();
        TRIG    = 1'b0;
        CLK_PE  = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < SIZE - 1; i++) sample(1'b0, 1'b0, 3);
        chk("coll_not_done", {31'd0, bus.DATA_VALID}, 32'd0);
        chk("coll_busy",     {31'd0, bus.BUSY}, 32'd1);
        sample(1'b0, 1'b0, 0);
        chk("coll_valid", {31'd0, bus.DATA_VALID}, 32'd1);
        chk("coll_data",  {24'd0, bus.DATA}, 32'h00);

        // ---------------- EN abort ----------------
        do_reset();
        do_capture(8'h4D, 1'b0);
        pulse_trig();
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b0, 3);
        EN = 1'b0;
        tick();
        chk("en_abort_busy", {31'd0, bus.BUSY}, 32'd0);
        pulse_trig();
        chk("en_trig_ignored", {31'd0, bus.BUSY}, 32'd0);
        EN = 1'b1;
        // Remaining ticks must not complete the abandoned capture
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b0, 3);
        chk("en_abort_data",  {24'd0, bus.DATA}, 32'h4D);
        chk("en_abort_valid", {31'd0, bus.DATA_VALID}, 32'd1);
        chk("en_abort_ovr",   {31'd0, bus.OVERRUN}, 32'd0);
        EN = 1'b0;
        pulse_ack();
        chk("en_off_ack", {31'd0, bus.DATA_VALID}, 32'd0);
        EN = 1'b1;

        // ---------------- RST abort ----------------
        do_reset();
        do_capture(8'h4D, 1'b0);
        pulse_trig();
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b0, 3);
        do_reset();
        chk("rst_abort_data",  {24'd0, bus.DATA}, 32'h00);
        chk("rst_abort_valid", {31'd0, bus.DATA_VALID}, 32'd0);
        chk("rst_abort_busy",  {31'd0, bus.BUSY}, 32'd0);
        chk("rst_abort_ovr",   {31'd0, bus.OVERRUN}, 32'd0);
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b0, 3);
        chk("rst_abort_noload", {31'd0, bus.DATA_VALID}, 32'd0);

        // ---------------- loopback with generator ----------------
        do_reset();
        loop_mode = 1'b1;
        gen_pat = 8'hC6;
        pulse_trig();
        for (int i = 0; i < SIZE; i++) begin
            CLK_PE = 1'b1;
            tick();
            CLK_PE = 1'b0;
            repeat (3) tick();
        end
        chk("loop0_data",  {24'd0, bus.DATA}, {24'd0, gen_pat});
        chk("loop0_valid", {31'd0, bus.DATA_VALID}, 32'd1);
        gen_pat = 8'h39;
        pulse_trig();
        for (int i = 0; i < SIZE; i++) begin
            CLK_PE = 1'b1;
            bus.DATA_ACK = (i == SIZE - 1);
            tick();
            CLK_PE = 1'b0;
            bus.DATA_ACK = 1'b0;
            repeat (3) tick();
        end
        chk("loop1_data", {24'd0, bus.DATA}, {24'd0, gen_pat});
        chk("loop1_ovr",  {31'd0, bus.OVERRUN}, 32'd0);
        loop_mode = 1'b0;

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
